// File: rtl/char_sdpb_clr.sv
// Simple dual-port char RAM with selectable read latency, same-address forwarding
// and a self-timed clear engine that sweeps the whole array to CLEAR_VAL.
module char_sdpb_clr #(
  parameter int                 DATA_W    = 8,
  parameter int                 ADDR_W    = 8,
  parameter int                 READ_MODE = 0,
  parameter int                 WR_FWD    = 1,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);
  localparam int                DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = '1;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_busy, r_done;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_ram_q;
  logic                r_v1, r_force1, r_fwd1, r_zero1;
  logic [DATA_W-1:0]   r_fwdd1;

  logic                w_clr;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_d1;

  // The clear engine owns the write port while sweeping; host writes are dropped.
  assign w_clr   = (r_state == S_CLEAR);
  assign w_we    = w_clr | wr_en;
  assign w_waddr = w_clr ? r_ptr : wr_addr;
  assign w_wdata = w_clr ? CLEAR_VAL : wr_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (clr_req) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_ptr == LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Block RAM: no reset on the array or its read register (read-first).
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (rd_en) r_ram_q <= r_mem[rd_addr];
  end

  // Side-band flags captured with each read select the post-RAM mux.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_v1     <= 1'b0;
      r_force1 <= 1'b0;
      r_fwd1   <= 1'b0;
      r_fwdd1  <= '0;
      r_zero1  <= 1'b1;
    end else begin
      r_v1 <= rd_en;
      if (rd_en) begin
        r_force1 <= w_clr;
        r_fwd1   <= (WR_FWD != 0) && w_we && (w_waddr == rd_addr);
        r_fwdd1  <= w_wdata;
        r_zero1  <= 1'b0;
      end
    end
  end

  assign w_d1 = r_zero1  ? '0        :
                r_force1 ? CLEAR_VAL :
                r_fwd1   ? r_fwdd1   : r_ram_q;

  generate
    if (READ_MODE == 1) begin : g_pipe
      logic              r_v2;
      logic [DATA_W-1:0] r_rd;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_v2 <= 1'b0;
          r_rd <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_rd <= w_d1;
        end
      end
      assign rd_valid = r_v2;
      assign rd_data  = r_rd;
    end else begin : g_byp
      assign rd_valid = r_v1;
      assign rd_data  = w_d1;
    end
  endgenerate

  assign clr_busy = r_busy;
  assign clr_done = r_done;
endmodule
